// File: rtl/instr_encoder_if.sv
// Command and instruction-memory write bus of the RV32I instruction encoder.
// The master issues symbolic commands and receives memory writes; the slave is the encoder.
interface instr_encoder_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [4:0]  cmd_rd;
    logic [4:0]  cmd_rs1;
    logic [4:0]  cmd_rs2;
    logic [31:0] cmd_imm;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  cmd_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output cmd_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic RV32I commands into machine words written to consecutive imem words.
// Define INSTR_ENCODER_RANGE_CHECK_EN to drop (and flag) commands whose immediate does not fit its field.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    instr_encoder_if.slave             bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       err
);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_JAL  = 4'd9;
    localparam logic [3:0] OP_JALR = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;

    typedef enum logic {LOAD, FULL} state_t;

    state_t      stateQ, stateD;
    logic        cmdReady, accept, legal, inRange, wrEn, lastSlot;
    logic [31:0] word;
    logic        weQ;
    logic [31:0] addrQ, wdataQ;

    function automatic logic [31:0] packR(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] packI(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] packS(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] packB(input logic [12:1] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] packJ(input logic [20:1] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] packU(input logic [31:12] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    function automatic logic fits(input logic signed [31:0] v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction
`endif

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (bus.cmd_op)
            OP_ADD:  word = packR(7'b0000000, 3'b000, bus.cmd_rd, bus.cmd_rs1, bus.cmd_rs2);
            OP_SUB:  word = packR(7'b0100000, 3'b000, bus.cmd_rd, bus.cmd_rs1, bus.cmd_rs2);
            OP_AND:  word = packR(7'b0000000, 3'b111, bus.cmd_rd, bus.cmd_rs1, bus.cmd_rs2);
            OP_OR:   word = packR(7'b0000000, 3'b110, bus.cmd_rd, bus.cmd_rs1, bus.cmd_rs2);
            OP_SLT:  word = packR(7'b0000000, 3'b010, bus.cmd_rd, bus.cmd_rs1, bus.cmd_rs2);
            OP_ADDI: word = packI(bus.cmd_imm[11:0], bus.cmd_rs1, 3'b000, bus.cmd_rd, 7'b0010011);
            OP_LW:   word = packI(bus.cmd_imm[11:0], bus.cmd_rs1, 3'b010, bus.cmd_rd, 7'b0000011);
            OP_SW:   word = packS(bus.cmd_imm[11:0], bus.cmd_rs2, bus.cmd_rs1);
            OP_BEQ:  word = packB(bus.cmd_imm[12:1], bus.cmd_rs2, bus.cmd_rs1);
            OP_JAL:  word = packJ(bus.cmd_imm[20:1], bus.cmd_rd);
            OP_JALR: word = packI(bus.cmd_imm[11:0], bus.cmd_rs1, 3'b000, bus.cmd_rd, 7'b1100111);
            OP_LUI:  word = packU(bus.cmd_imm[31:12], bus.cmd_rd);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        inRange = 1'b1;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        case (bus.cmd_op)
            OP_ADDI, OP_LW, OP_SW, OP_JALR: inRange = fits(bus.cmd_imm, -2048, 2047);
            OP_BEQ:  inRange = fits(bus.cmd_imm, -4096, 4094) && !bus.cmd_imm[0];
            OP_JAL:  inRange = fits(bus.cmd_imm, -1048576, 1048574) && !bus.cmd_imm[0];
            OP_LUI:  inRange = (bus.cmd_imm[11:0] == 12'h000);
            default: inRange = 1'b1;
        endcase
`endif
    end

    assign lastSlot = (count == CNT_W'(DEPTH - 1));

    always_comb begin
        stateD   = stateQ;
        cmdReady = (stateQ == LOAD) && !clear;
        accept   = bus.cmd_valid && cmdReady;
        wrEn     = accept && legal && inRange;
        if (clear)
            stateD = LOAD;
        else if (wrEn && lastSlot)
            stateD = FULL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stateQ <= LOAD;
        else
            stateQ <= stateD;
    end

    // Write stage: the accepted word appears on the imem bus for exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weQ    <= 1'b0;
            addrQ  <= BASE_ADDR;
            wdataQ <= '0;
            count  <= '0;
            full   <= 1'b0;
            err    <= 1'b0;
        end else if (clear) begin
            weQ    <= 1'b0;
            addrQ  <= BASE_ADDR;
            count  <= '0;
            full   <= 1'b0;
            err    <= 1'b0;
        end else begin
            weQ <= wrEn;
            if (wrEn) begin
                addrQ  <= BASE_ADDR + (32'(count) << 2);
                wdataQ <= word;
                count  <= count + CNT_W'(1);
                full   <= lastSlot;
            end
            if (accept && !wrEn)
                err <= 1'b1;
        end
    end

    assign bus.cmd_ready  = cmdReady;
    assign bus.imem_we    = weQ;
    assign bus.imem_addr  = addrQ;
    assign bus.imem_wdata = wdataQ;
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table through a write scoreboard plus
// hand-written sequences for back-to-back, full, clear and reset corner cases.
module tb_instr_encoder;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          CW    = $clog2(DEPTH + 1);

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic [CW-1:0] count;
    logic          full;
    logic          err;

    instr_encoder_if bus();

    instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus),
        .count (count),
        .full  (full),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        bit          wr;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cnt;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[15];
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   modelCount = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Every write strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.imem_we !== 1'b0) begin
            if (sbq.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_write: got 0x%08h @0x%08h, expected no write",
                         bus.imem_wdata, bus.imem_addr);
            end else begin
                e = sbq.pop_front();
                check("wr_addr", bus.imem_addr, e.addr);
                check("wr_data", bus.imem_wdata, e.data);
                check("wr_count", 32'(count), 32'(e.cnt));
                check("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Starts and returns 1 time unit after a rising edge; wr=0 means no write is expected.
    task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input bit wr,
                         input logic [31:0] word);
        bit rdy;
        bit done;
        done = 1'b0;
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_rs1   = rs1;
        bus.cmd_rs2   = rs2;
        bus.cmd_imm   = imm;
        bus.cmd_valid = 1'b1;
        for (int t = 0; t < 10 && !done; t++) begin
            @(negedge clk);
            rdy = bus.cmd_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                done = 1'b1;
                if (wr) begin
                    sbq.push_back('{BASE + 32'(4 * modelCount), word, modelCount + 1, cyc});
                    modelCount++;
                end
            end
        end
        if (!done) begin
            tests++;
            failed++;
            $display("FAIL accept_timeout: got cmd_ready=0 for 10 cycles, expected acceptance");
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic doClear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        modelCount = 0;
        check("clr_count", 32'(count), 32'd0);
        check("clr_full", 32'(full), 32'd0);
        check("clr_err", 32'(err), 32'd0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_rd    = '0;
        bus.cmd_rs1   = '0;
        bus.cmd_rs2   = '0;
        bus.cmd_imm   = '0;

        vecs[0]  = '{4'd0,  5'd3,  5'd1,  5'd2,  32'd0,        1'b1, 32'h002081B3};
        vecs[1]  = '{4'd1,  5'd1,  5'd2,  5'd3,  32'd0,        1'b1, 32'h403100B3};
        vecs[2]  = '{4'd2,  5'd4,  5'd5,  5'd6,  32'd0,        1'b1, 32'h0062F233};
        vecs[3]  = '{4'd3,  5'd7,  5'd8,  5'd9,  32'd0,        1'b1, 32'h009463B3};
        vecs[4]  = '{4'd13, 5'd1,  5'd1,  5'd1,  32'd0,        1'b0, 32'h0};
        vecs[5]  = '{4'd4,  5'd10, 5'd11, 5'd12, 32'd0,        1'b1, 32'h00C5A533};
        vecs[6]  = '{4'd5,  5'd1,  5'd0,  5'd0,  32'hFFFFFFFF, 1'b1, 32'hFFF00093};
        vecs[7]  = '{4'd6,  5'd5,  5'd2,  5'd0,  32'd8,        1'b1, 32'h00812283};
        vecs[8]  = '{4'd7,  5'd31, 5'd0,  5'd1,  32'd4,        1'b1, 32'h00102223};
        vecs[9]  = '{4'd8,  5'd7,  5'd1,  5'd2,  32'hFFFFFFF8, 1'b1, 32'hFE208CE3};
        vecs[10] = '{4'd9,  5'd1,  5'd0,  5'd0,  32'd2048,     1'b1, 32'h001000EF};
        vecs[11] = '{4'd10, 5'd1,  5'd5,  5'd0,  32'd12,       1'b1, 32'h00C280E7};
        vecs[12] = '{4'd11, 5'd2,  5'd0,  5'd0,  32'h12345000, 1'b1, 32'h12345137};
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        vecs[13] = '{4'd5,  5'd1,  5'd0,  5'd0,  32'd2048,     1'b0, 32'h0};
`else
        vecs[13] = '{4'd5,  5'd1,  5'd0,  5'd0,  32'd2048,     1'b1, 32'h80000093};
`endif
        vecs[14] = '{4'd15, 5'd0,  5'd0,  5'd0,  32'd0,        1'b0, 32'h0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we", 32'(bus.imem_we), 32'd0);
        check("rst_addr", bus.imem_addr, BASE);
        check("rst_wdata", bus.imem_wdata, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single ADD, then back-to-back LW/SW followed by clear racing a command
        issue(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
        @(posedge clk);
        #1;
        doClear();
        issue(4'd6, 5'd5, 5'd2, 5'd0, 32'd8, 1'b1, 32'h00812283);
        issue(4'd7, 5'd0, 5'd0, 5'd1, 32'd4, 1'b1, 32'h00102223);
        clear = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'd0;
        @(negedge clk);
        check("clr_wins_ready", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        bus.cmd_valid = 1'b0;
        modelCount = 0;
        @(negedge clk);
        check("clr_wins_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;

        // Vector table
        doClear();
        for (int i = 0; i < 15; i++) begin
            if (modelCount == DEPTH) doClear();
            issue(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
                  vecs[i].wr, vecs[i].word);
            if (!vecs[i].wr) begin
                check($sformatf("vec%0d_err", i), 32'(err), 32'd1);
                check($sformatf("vec%0d_count", i), 32'(count), 32'(modelCount));
            end
        end
        @(posedge clk);
        #1;

        // Fill to DEPTH with valid held, fifth command must wait for clear
        doClear();
        for (int k = 0; k < DEPTH; k++)
            issue(4'd5, 5'(k + 1), 5'd0, 5'd0, 32'(k), 1'b1,
                  (32'(k) << 20) | (32'(k + 1) << 7) | 32'h13);
        check("full_flag", 32'(full), 32'd1);
        check("full_count", 32'(count), 32'(DEPTH));
        bus.cmd_op    = 4'd5;
        bus.cmd_rd    = 5'd9;
        bus.cmd_imm   = 32'd5;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("full_ready%0d", k), 32'(bus.cmd_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(negedge clk);
        check("full_clr_ready", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        bus.cmd_valid = 1'b0;
        modelCount = 0;
        @(negedge clk);
        check("after_clr_count", 32'(count), 32'd0);
        check("after_clr_full", 32'(full), 32'd0);
        check("after_clr_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        issue(4'd5, 5'd9, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500493);
        @(posedge clk);
        #1;

        // Reset arriving while a write is pending
        doClear();
        issue(4'd12, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0);
        issue(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        check("prst_we", 32'(bus.imem_we), 32'd0);
        check("prst_count", 32'(count), 32'd0);
        check("prst_err", 32'(err), 32'd0);
        check("prst_addr", bus.imem_addr, BASE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelCount = 0;
        @(negedge clk);
        check("prst_ready", 32'(bus.cmd_ready), 32'd1);

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder and program loader: the inverse of the control decoder. Accepts symbolic instruction commands (operation, register indices, immediate) over a valid/ready handshake, packs each into a 32-bit RV32I machine word, and writes it into instruction memory at consecutive word addresses. Used by bring-up benches and the boot loader to build programs without hand-assembling hex.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word (word-aligned)
- DEPTH, 256, maximum number of words written before full

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous restart: write pointer back to BASE_ADDR, flags cleared
- cmd_valid  input  1  command present
- cmd_ready  output  1  encoder can accept a command this cycle
- cmd_op  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 ADDI, 6 LW, 7 SW, 8 BEQ, 9 JAL, 10 JALR, 11 LUI, 12-15 illegal
- cmd_rd, cmd_rs1, cmd_rs2  input  5 each  register indices (unused fields ignored)
- cmd_imm  input  32  signed immediate (byte offset for BEQ/JAL; LUI takes cmd_imm[31:12])
- imem_we  output  1  one-cycle write strobe
- imem_addr  output  32  byte address of the write
- imem_wdata  output  32  encoded instruction
- count  output  $clog2(DEPTH+1)  words written since reset/clear
- full  output  1  count == DEPTH
- err  output  1  sticky: an illegal or out-of-range command was dropped

## Operation
- FSM states: LOAD (accepting), FULL (count == DEPTH). LOAD -> FULL when the DEPTH-th word is written; FULL -> LOAD only on clear.
- cmd_ready = (state == LOAD) && !clear. Accept = cmd_valid && cmd_ready.
- Encoding (opcode / funct3 / funct7): ADD 0110011/000/0000000; SUB 0110011/000/0100000; AND 0110011/111/0; OR 0110011/110/0; SLT 0110011/010/0; ADDI 0010011/000 I-type; LW 0000011/010 I-type; SW 0100011/010 S-type; BEQ 1100011/000 B-type; JAL 1101111 J-type; JALR 1100111/000 I-type; LUI 0110111 U-type.
- Immediate packing per RV32I: I imm[11:0]; S imm[11:5]/imm[4:0]; B imm[12|10:5] / imm[4:1|11]; J imm[20|10:1|11|19:12]; U imm[31:12].
- Illegal op (12-15): command is consumed, no write, err set, pointer unchanged.
- Write pointer advances by 4 per written word; imem_addr = BASE_ADDR + 4*count at write time. count never exceeds DEPTH.
- Dropped commands never count toward full.

## Timing
- Reset (async, rst_n low): imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, full=0, err=0, state LOAD; cmd_ready=1 once rst_n is high and clear low. A write pending at reset assertion is discarded immediately.
- Latency: command accepted at edge N -> imem_we=1 with addr/data valid during cycle N+1, for exactly one cycle. count/full update at the same edge that raises imem_we.
- Throughput: one command per cycle; back-to-back accepts give back-to-back writes at increasing addresses.
- Last slot: accepting the DEPTH-th command drops cmd_ready in the following cycle (full=1 together with its imem_we).
- clear and cmd_valid in the same cycle: clear wins, command not accepted. A write already registered from the previous cycle still completes at its old address; pointer then restarts at BASE_ADDR.
- err is sticky until clear or reset.

## Configuration
- INSTR_ENCODER_RANGE_CHECK_EN defined: commands with immediates out of range are dropped and set err: I/S outside -2048..2047; B outside -4096..4094 or odd; J outside -1048576..1048574 or odd; LUI with cmd_imm[11:0] != 0.
- Not defined: no range check; immediates silently truncated to the field bits (bit 0 of B/J ignored); only illegal ops set err.

## Test plan
- Reset, then ADD rd=3 rs1=1 rs2=2 -> one cycle later imem_we=1, imem_addr=0x0, imem_wdata=0x002081B3, count=1.
- Back-to-back LW rd=5 rs1=2 imm=8 then SW rs1=0 rs2=1 imm=4 -> writes 0x00812283 @0x0 then 0x00102223 @0x4 on consecutive cycles.
- DEPTH=4, five valid commands held valid -> four writes @0x0..0xC, full=1, cmd_ready=0, fifth not accepted; clear -> cmd_ready=1, count=0, next write @0x0.
- cmd_op=13 -> no imem_we, err=1, count unchanged; ADDI rd=1 rs1=0 imm=2048 -> with macro: dropped, err=1; without: written as 0x80000093.
- BEQ rs1=1 rs2=2 imm=-8 -> imem_wdata=0xFE208CE3; JAL rd=1 imm=2048 -> 0x001000EF.
- rst_n pulsed low in the cycle after an accept -> imem_we never asserts, count=0, err=0, imem_addr=BASE_ADDR.
